// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a small registered instruction
// buffer and single-outstanding-request memory handshake.
// Build option: define FETCH_PREFETCH_EN for a 2-entry buffer (one instruction
// per cycle); otherwise the buffer holds a single entry.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc8,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

`ifdef FETCH_PREFETCH_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  typedef enum logic {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } state_t;

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] hold_addr, hold_addr_n;
  logic [1:0]  count, count_n, count_p;
  logic [31:0] redirect_tgt;
  logic        accept, push, pop;

  // Buffer slots hold the instruction and its address + 8, so the R15 read
  // value comes straight from a register and resets to zero.
  logic [31:0] h_instr, h_instr_n, h_pc8, h_pc8_n;
`ifdef FETCH_PREFETCH_EN
  logic [31:0] t_instr, t_instr_n, t_pc8, t_pc8_n;
`endif

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // Memory-side and decode-side outputs; the request is killed as soon as reset asserts.
  always_comb begin
    imem_req    = reset & ((state == DISCARD) | (count < DEPTH));
    imem_addr   = (state == DISCARD) ? hold_addr : fetch_pc;
    instr_valid = (count != 2'd0);
    instr       = h_instr;
    instr_pc8   = h_pc8;
  end

  // Handshake qualifiers; a redirect cancels any push into the buffer.
  always_comb begin
    accept  = imem_req & imem_ready;
    pop     = instr_valid & instr_ready;
    push    = accept & (state == RUN) & ~redirect;
    count_p = count - {1'b0, pop};
  end

  // FSM next state, fetch PC, hold address and occupancy.
  always_comb begin
    state_n     = state;
    hold_addr_n = hold_addr;
    fetch_pc_n  = fetch_pc;
    count_n     = count_p + {1'b0, push};
    case (state)
      RUN: begin
        if (redirect && imem_req && !imem_ready) begin
          hold_addr_n = fetch_pc;
          state_n     = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_ready) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
    if (redirect) begin
      fetch_pc_n = redirect_tgt;
      count_n    = 2'd0;
    end else if (push) begin
      fetch_pc_n = fetch_pc + 32'd4;
    end
  end

  // Buffer slot updates: a pop shifts the tail to the head, a push fills the first free slot.
  always_comb begin
    h_instr_n = h_instr;
    h_pc8_n   = h_pc8;
`ifdef FETCH_PREFETCH_EN
    t_instr_n = t_instr;
    t_pc8_n   = t_pc8;
    if (pop) begin
      h_instr_n = t_instr;
      h_pc8_n   = t_pc8;
    end
    if (push) begin
      if (count_p == 2'd0) begin
        h_instr_n = imem_rdata;
        h_pc8_n   = fetch_pc + 32'd8;
      end else begin
        t_instr_n = imem_rdata;
        t_pc8_n   = fetch_pc + 32'd8;
      end
    end
`else
    if (push) begin
      h_instr_n = imem_rdata;
      h_pc8_n   = fetch_pc + 32'd8;
    end
`endif
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      hold_addr <= '0;
      count     <= '0;
      h_instr   <= '0;
      h_pc8     <= '0;
`ifdef FETCH_PREFETCH_EN
      t_instr   <= '0;
      t_pc8     <= '0;
`endif
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      hold_addr <= hold_addr_n;
      count     <= count_n;
      h_instr   <= h_instr_n;
      h_pc8     <= h_pc8_n;
`ifdef FETCH_PREFETCH_EN
      t_instr   <= t_instr_n;
      t_pc8     <= t_pc8_n;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table vectors, directed corner sequences and randomized
// traffic against a queue-based reference model of the fetch buffer.
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc8;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc8   (instr_pc8),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of buffered {instruction, address+8}, fetch PC,
  // and a pending-discard flag with the address that must stay on the bus.
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc8;
  } item_t;
  item_t       mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_hold;
  logic        m_disc;

  // Outputs sampled during the last tick.
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc8;

  typedef struct {
    logic        rdy;
    logic [31:0] rdata;
    logic        ird;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc8;
  } vec_t;
  vec_t vt[6];
  int   nv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_pc   = 32'h0000_0000;
    m_hold = 32'h0000_0000;
    m_disc = 1'b0;
  endfunction

  // One clock cycle: drive inputs, check against the model away from the
  // edge, then advance the model on the rising edge.
  task automatic tick(input logic rdy, input logic [31:0] rd, input logic ird,
                      input logic rdr, input logic [31:0] rpc);
    logic        e_req;
    logic [31:0] tgt;
    item_t       it;
    imem_ready  = rdy;
    imem_rdata  = rd;
    instr_ready = ird;
    redirect    = rdr;
    redirect_pc = rpc;
    @(negedge clk);
    e_req = m_disc || (mq.size() < DEPTH);
    chk1("imem_req", imem_req, e_req);
    if (e_req) chk("imem_addr", imem_addr, m_disc ? m_hold : m_pc);
    chk1("instr_valid", instr_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("instr", instr, mq[0].ins);
      chk("instr_pc8", instr_pc8, mq[0].pc8);
    end
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_instr = instr; s_pc8 = instr_pc8;
    @(posedge clk);
    tgt = {rpc[31:2], 2'b00};
    if (m_disc) begin
      if (rdr) m_pc = tgt;
      if (rdy) m_disc = 1'b0;
    end else if (rdr) begin
      if (e_req && !rdy) begin
        m_hold = m_pc;
        m_disc = 1'b1;
      end
      mq.delete();
      m_pc = tgt;
    end else begin
      if (mq.size() > 0 && ird) void'(mq.pop_front());
      if (e_req && rdy) begin
        it.ins = rd;
        it.pc8 = m_pc + 32'd8;
        mq.push_back(it);
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  // Asynchronous reset in the middle of a cycle, then release after one edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk1("rst_imem_req", imem_req, 1'b0);
    chk1("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc8", instr_pc8, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    imem_ready  = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    model_reset();

    // Streaming after reset release with zero-wait memory.
`ifdef FETCH_PREFETCH_EN
    nv = 4;
    vt[0] = '{1'b1, 32'hE3A0_1005, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0,         32'h0};
    vt[1] = '{1'b1, 32'h1111_1111, 1'b1, 1'b1, 32'h4,  1'b1, 32'hE3A0_1005, 32'h8};
    vt[2] = '{1'b1, 32'h2222_2222, 1'b1, 1'b1, 32'h8,  1'b1, 32'h1111_1111, 32'hC};
    vt[3] = '{1'b1, 32'h3333_3333, 1'b1, 1'b1, 32'hC,  1'b1, 32'h2222_2222, 32'h10};
`else
    nv = 6;
    vt[0] = '{1'b1, 32'hE3A0_1005, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0,         32'h0};
    vt[1] = '{1'b1, 32'h0BAD_0BAD, 1'b1, 1'b0, 32'h0,  1'b1, 32'hE3A0_1005, 32'h8};
    vt[2] = '{1'b1, 32'h1111_1111, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0,         32'h0};
    vt[3] = '{1'b1, 32'h0BAD_0BAD, 1'b1, 1'b0, 32'h0,  1'b1, 32'h1111_1111, 32'hC};
    vt[4] = '{1'b1, 32'h2222_2222, 1'b1, 1'b1, 32'h8,  1'b0, 32'h0,         32'h0};
    vt[5] = '{1'b1, 32'h0BAD_0BAD, 1'b1, 1'b0, 32'h0,  1'b1, 32'h2222_2222, 32'h10};
`endif

    #3;
    chk1("init_imem_req", imem_req, 1'b0);
    chk1("init_instr_valid", instr_valid, 1'b0);
    chk("init_instr", instr, 32'h0);
    chk("init_instr_pc8", instr_pc8, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < nv; i++) begin
      tick(vt[i].rdy, vt[i].rdata, vt[i].ird, 1'b0, 32'h0);
      chk1("vec_req", s_req, vt[i].e_req);
      if (vt[i].e_req) chk("vec_addr", s_addr, vt[i].e_addr);
      chk1("vec_valid", s_valid, vt[i].e_valid);
      if (vt[i].e_valid) begin
        chk("vec_instr", s_instr, vt[i].e_instr);
        chk("vec_pc8", s_pc8, vt[i].e_pc8);
      end
    end

    // Decode stalls for 5 cycles: head stays at address 0, requests stop when full.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
      if (i >= 1) chk("stall_pc8_held", s_pc8, 32'h8);
      if (i == 4) chk1("stall_req_dropped", s_req, 1'b0);
    end
    for (int i = 0; i < 8; i++) tick(1'b1, $urandom, 1'b1, 1'b0, 32'h0);

    // Redirect during a 3-cycle wait state.
    do_reset();
    tick(1'b0, 32'hDEAD_0001, 1'b1, 1'b1, 32'h0000_0103);
    chk("wait_addr0", s_addr, 32'h0);
    tick(1'b0, 32'hDEAD_0002, 1'b1, 1'b0, 32'h0);
    chk1("wait_req1", s_req, 1'b1);
    chk("wait_addr1", s_addr, 32'h0);
    tick(1'b0, 32'hDEAD_0003, 1'b1, 1'b0, 32'h0);
    chk("wait_addr2", s_addr, 32'h0);
    tick(1'b1, 32'hDEAD_0004, 1'b1, 1'b0, 32'h0);
    chk("wait_addr3", s_addr, 32'h0);
    tick(1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
    chk1("wait_dropped", s_valid, 1'b0);
    chk("wait_new_addr", s_addr, 32'h0000_0100);
    tick(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("wait_new_instr", s_instr, 32'h1234_5678);
    chk("wait_new_pc8", s_pc8, 32'h0000_0108);

    // Redirect with offered response and pop while the buffer is full.
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 32'hFEED_FACE, 1'b1, 1'b1, 32'h0000_0206);
    tick(1'b1, 32'hCAFE_0001, 1'b1, 1'b0, 32'h0);
    chk1("full_redir_valid", s_valid, 1'b0);
    chk1("full_redir_req", s_req, 1'b1);
    chk("full_redir_addr", s_addr, 32'h0000_0204);

    // Reset while in the discard state.
    do_reset();
    tick(1'b0, $urandom, 1'b1, 1'b1, 32'h0000_0300);
    tick(1'b0, $urandom, 1'b1, 1'b0, 32'h0);
    do_reset();
    tick(1'b1, 32'hABCD_0000, 1'b1, 1'b0, 32'h0);
    chk("disc_rst_restart", s_addr, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        tick($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
             $urandom_range(0, 19) == 0, $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_req  output  1  instruction memory request.
REQ-005 SHALL have port imem_addr  output  32  word-aligned request address.
REQ-006 SHALL have port imem_ready  input  1  memory accepts the request and returns data in the same cycle.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, valid when imem_req & imem_ready.
REQ-008 SHALL have port instr_valid  output  1  buffer head holds a valid instruction for decode.
REQ-009 SHALL have port instr  output  32  head instruction; feeds decode (Op = instr[27:26], Funct = instr[25:20], Rd = instr[15:12]).
REQ-010 SHALL have port instr_pc8  output  32  head instruction address + 8 (R15 read value).
REQ-011 SHALL have port instr_ready  input  1  decode consumes the head when instr_valid & instr_ready.
REQ-012 SHALL have port redirect  input  1  taken branch or PC write (PCSrc) from the execute side.
REQ-013 SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] ignored, forced to 00.

Function
REQ-014 SHALL keep a FIFO of DEPTH entries {instr, addr}, with registered count; push = accepted, non-discarded response; pop = instr_valid & instr_ready.
REQ-015 SHALL implement FSM RUN and DISCARD; imem_req = DISCARD | (RUN & count < DEPTH), where count is the registered value with no same-cycle pop credit.
REQ-016 SHALL drive imem_addr = fetch_pc in RUN and hold_addr in DISCARD; address stays stable while imem_req=1 and imem_ready=0.
REQ-017 SHALL, on an accepted response in RUN without redirect, push the data with addr = fetch_pc and set fetch_pc += 4 (mod 2^32).
REQ-018 SHALL register the buffer: data accepted in cycle N is visible on instr/instr_valid in cycle N+1 at the earliest.
REQ-019 SHALL, on redirect, flush all FIFO entries, set count 0 and fetch_pc = {redirect_pc[31:2],2'b00}; redirect overrides a same-cycle push and pop.
REQ-020 SHALL, on redirect in RUN with imem_req=1 and imem_ready=0, load hold_addr = fetch_pc and go to DISCARD.
REQ-021 SHALL, on redirect in RUN with imem_req & imem_ready, drop the returned data and stay in RUN.
REQ-022 SHALL, in DISCARD on imem_ready, drop the data and return to RUN; a redirect in DISCARD updates fetch_pc only and stays in DISCARD unless imem_ready.
REQ-023 SHALL hold instr/instr_pc8 stable while instr_valid=1 and instr_ready=0.
REQ-024 SHALL allow at most one outstanding memory request.

Reset
REQ-025 SHALL, while reset=0, force state RUN, fetch_pc = RESET_PC, count 0, instr_valid 0, instr 0, instr_pc8 0, hold_addr 0; imem_req may assert in the first cycle after release.
REQ-026 SHALL, on reset asserted mid-request, drop the request immediately with no response consumed.

Configuration
REQ-027 SHALL, with macro FETCH_PREFETCH_EN defined, use DEPTH=2, sustaining one instruction per cycle with zero-wait memory and instr_ready=1.
REQ-028 SHALL, without FETCH_PREFETCH_EN, use DEPTH=1, giving at most one instruction every 2 cycles; all other behaviour is identical.

Verification
REQ-029 SHALL cover reset release with RESET_PC=0, imem_ready=1, imem_rdata=32'hE3A0_1005, instr_ready=1 -> imem_addr 0 in cycle 0, instr_valid=1, instr=32'hE3A0_1005, instr_pc8=8 in cycle 1.
REQ-030 SHALL cover streaming with PREFETCH_EN, zero-wait memory -> addresses 0,4,8,C on consecutive cycles; without the macro -> 0,4,8 every other cycle.
REQ-031 SHALL cover instr_ready=0 for 5 cycles -> imem_req drops once count=DEPTH, instr held at addr 0, no address skipped after release.
REQ-032 SHALL cover redirect to 32'h0000_0103 during a 3-cycle wait state -> DISCARD, old address held until ready, that data dropped, next request addr 32'h0000_0100.
REQ-033 SHALL cover redirect with a same-cycle response and pop at full FIFO -> count 0, instr_valid=0 next cycle, next address = redirect target.
REQ-034 SHALL cover reset asserted during DISCARD -> imem_req=0, instr_valid=0 immediately, fetch restarts at RESET_PC.
